// File: rtl/axil_seq_pkg.sv
// axil_seq_pkg: shared FSM state type and AXI4-Lite constants for axil_seq_master
//   contents: state_t enum, AXI response codes, default PROT and full-word STRB values
package axil_seq_pkg;
   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
   localparam logic [3:0] AXI_STRB_FULL    = 4'hF;
endpackage

// File: rtl/axil_seq_master.sv
// axil_seq_master: AXI4-Lite master that writes an incrementing word pattern, reads it back and checks it
//   m00_axi_aclk/m00_axi_areset : clock, asynchronous active-high reset
//   init_txn                    : start request (rising edge)
//   busy/done/error             : sequence running / end pulse / sticky failure flag
//   m00_axi_aw*/w*/b*/ar*/r*    : AXI4-Lite master channels, one transaction outstanding
module axil_seq_master #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = '0,
   parameter int unsigned C_M_TXN_NUM = 4,
   parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_M_START_DATA = 32'h1,
   parameter int unsigned C_M_TIMEOUT = 1024
) (
   input  logic                            m00_axi_aclk,
   input  logic                            m00_axi_areset,
   input  logic                            init_txn,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
   output logic [2:0]                      m00_axi_awprot,
   output logic                            m00_axi_awvalid,
   input  logic                            m00_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
   output logic                            m00_axi_wvalid,
   input  logic                            m00_axi_wready,
   input  logic [1:0]                      m00_axi_bresp,
   input  logic                            m00_axi_bvalid,
   output logic                            m00_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
   output logic [2:0]                      m00_axi_arprot,
   output logic                            m00_axi_arvalid,
   input  logic                            m00_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
   input  logic [1:0]                      m00_axi_rresp,
   input  logic                            m00_axi_rvalid,
   output logic                            m00_axi_rready
);
   import axil_seq_pkg::*;
   state_t r_state, w_state_next;
   logic r_init_q, r_init_qq, r_error;
   logic r_awvalid, r_wvalid, r_arvalid, r_aw_done, r_w_done;
   logic [8:0] r_idx;
   logic [31:0] r_tmo;
   logic w_start, w_aw_ok, w_w_ok, w_tmo, w_last, w_step, w_bad_b, w_bad_r, w_leave;
   logic [C_M_AXI_ADDR_WIDTH-1:0] w_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0] w_data;
   assign w_start = r_init_q & ~r_init_qq;
   // a channel counts as accepted once its handshake happened, now or earlier in this phase
   assign w_aw_ok = r_aw_done | (r_awvalid & m00_axi_awready);
   assign w_w_ok  = r_w_done | (r_wvalid & m00_axi_wready);
   assign w_tmo   = r_state != IDLE && r_state != DONE && r_tmo == C_M_TIMEOUT;
   assign w_last  = r_idx == 9'(C_M_TXN_NUM - 1);
   assign w_step  = (r_state == WR_RESP && m00_axi_bvalid) || (r_state == RD_DATA && m00_axi_rvalid);
   assign w_addr  = C_M_TARGET_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({r_idx, 2'b00});
   assign w_data  = C_M_START_DATA + C_M_AXI_DATA_WIDTH'(r_idx);
   assign w_bad_b = r_state == WR_RESP && m00_axi_bvalid && m00_axi_bresp != AXI_RESP_OKAY;
   assign w_bad_r = r_state == RD_DATA && m00_axi_rvalid &&
                    (m00_axi_rdata != w_data || m00_axi_rresp != AXI_RESP_OKAY);
   assign w_leave = w_state_next != r_state;
   assign m00_axi_awaddr  = w_addr;
   assign m00_axi_araddr  = w_addr;
   assign m00_axi_wdata   = w_data;
   assign m00_axi_awprot  = AXI_PROT_DEFAULT;
   assign m00_axi_arprot  = AXI_PROT_DEFAULT;
   assign m00_axi_wstrb   = AXI_STRB_FULL;
   assign m00_axi_awvalid = r_awvalid;
   assign m00_axi_wvalid  = r_wvalid;
   assign m00_axi_arvalid = r_arvalid;
   assign error           = r_error;
   always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset)
      if (m00_axi_areset) r_state <= IDLE;
      else r_state <= w_state_next;
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    w_state_next = w_start ? WR_ADDR : IDLE;
         WR_ADDR: w_state_next = w_tmo ? DONE : (w_aw_ok & w_w_ok) ? WR_RESP : WR_ADDR;
         WR_RESP: w_state_next = w_tmo ? DONE : !m00_axi_bvalid ? WR_RESP : w_last ? RD_ADDR : WR_ADDR;
         RD_ADDR: w_state_next = w_tmo ? DONE : (r_arvalid & m00_axi_arready) ? RD_DATA : RD_ADDR;
         RD_DATA: w_state_next = w_tmo ? DONE : !m00_axi_rvalid ? RD_DATA : w_last ? DONE : RD_ADDR;
         default: w_state_next = IDLE;
      endcase
   end
   always_comb begin
      busy           = r_state != IDLE && r_state != DONE;
      done           = r_state == DONE;
      m00_axi_bready = r_state == WR_RESP;
      m00_axi_rready = r_state == RD_DATA;
   end
   // valids are registered so they rise the cycle after phase entry and clear on any state change
   always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset)
      if (m00_axi_areset) begin
         r_init_q  <= 1'b0;
         r_init_qq <= 1'b0;
         r_error   <= 1'b0;
         r_idx     <= '0;
         r_tmo     <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_arvalid <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_init_q  <= init_txn;
         r_init_qq <= r_init_q;
         r_error   <= (r_state == IDLE && w_start) ? 1'b0 : r_error | w_tmo | w_bad_b | w_bad_r;
         r_idx     <= r_state == IDLE ? '0 : w_step ? (w_last ? '0 : r_idx + 9'd1) : r_idx;
         r_tmo     <= w_leave ? '0 : r_tmo + 32'd1;
         r_awvalid <= !w_leave && r_state == WR_ADDR && (r_awvalid ? !m00_axi_awready : !r_aw_done);
         r_wvalid  <= !w_leave && r_state == WR_ADDR && (r_wvalid ? !m00_axi_wready : !r_w_done);
         r_aw_done <= !w_leave && r_state == WR_ADDR && w_aw_ok;
         r_w_done  <= !w_leave && r_state == WR_ADDR && w_w_ok;
         r_arvalid <= !w_leave && r_state == RD_ADDR;
      end
endmodule

// File: tb/tb_axil_seq_master.sv
// tb_axil_seq_master: directed bench for axil_seq_master against a reactive AXI4-Lite slave model
module tb_axil_seq_master;
   logic clk = 1'b0, rst = 1'b1, init_txn = 1'b0;
   logic busy, done, error;
   logic [31:0] awaddr, wdata, araddr;
   logic [2:0] awprot, arprot;
   logic [3:0] wstrb;
   logic awvalid, wvalid, arvalid, bready, rready;
   logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0] bresp = 2'b00, rresp = 2'b00;
   logic [31:0] rdata = '0;
   always #5 clk = ~clk;
   axil_seq_master #(.C_M_TIMEOUT(16)) dut (
      .m00_axi_aclk(clk), .m00_axi_areset(rst), .init_txn(init_txn),
      .busy(busy), .done(done), .error(error),
      .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
      .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
      .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
      .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
      .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
   );
   int n_tests = 0, n_fail = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   logic [31:0] mem [0:63];
   logic [31:0] wr_a_log [0:255], wr_d_log [0:255], rd_a_log [0:255];
   int cfg_aw_dly [0:255], cfg_w_dly [0:255];
   int bad_b_word = -1, bad_r_word = -1;
   bit ar_never = 1'b0;
   int wr_n = 0, rd_n = 0, drop_n = 0, arv_n = 0, done_n = 0;
   int aw_cnt = 0, w_cnt = 0;
   bit aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
   logic [31:0] aw_a = '0, w_d = '0, ar_a = '0;
   logic p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
   // slave acts on the falling edge; a ready driven high here completes a handshake on the next rising edge
   always @(negedge clk) begin
      if (rst) begin
         awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
         aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; w_cnt = 0;
         p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
      end else begin
         if ((p_awv && !p_awr && !awvalid) || (p_wv && !p_wr && !wvalid) || (p_arv && !p_arr && !arvalid))
            drop_n++;
         if (done) done_n++;
         if (arvalid) arv_n++;
         if (awready) begin awready = 0; aw_got = 1; end
         else if (awvalid && !aw_got) begin
            if (aw_cnt >= cfg_aw_dly[wr_n]) begin awready = 1; aw_a = awaddr; end
            else aw_cnt++;
         end
         if (wready) begin wready = 0; w_got = 1; end
         else if (wvalid && !w_got) begin
            if (w_cnt >= cfg_w_dly[wr_n]) begin wready = 1; w_d = wdata; end
            else w_cnt++;
         end
         if (bvalid) bvalid = 0;
         else if (aw_got && w_got && bready) begin
            mem[aw_a[7:2]] = w_d;
            wr_a_log[wr_n] = aw_a;
            wr_d_log[wr_n] = w_d;
            bresp = (int'(aw_a[7:2]) == bad_b_word) ? 2'b10 : 2'b00;
            bvalid = 1; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
            wr_n++;
         end
         if (arready) begin arready = 0; ar_got = 1; end
         else if (arvalid && !ar_got && !ar_never) begin arready = 1; ar_a = araddr; end
         if (rvalid) rvalid = 0;
         else if (ar_got && rready) begin
            rdata = (int'(ar_a[7:2]) == bad_r_word) ? 32'hDEAD : mem[ar_a[7:2]];
            rresp = 2'b00; rvalid = 1; ar_got = 0;
            rd_a_log[rd_n] = ar_a;
            rd_n++;
         end
         p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready; p_arv = arvalid; p_arr = arready;
      end
   end
   // lat = negedge count from the init_txn rise to the done pulse (0 if it never came)
   task automatic run(input bit hold, input int repulse, output int lat, output logic err2);
      @(negedge clk) init_txn = 1;
      lat = 0;
      err2 = 1'bx;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) init_txn = 0;
         if (k == repulse) init_txn = 1;
         if (k == repulse + 1) init_txn = 0;
         if (k == 2) err2 = error;
         if (done) begin lat = k; break; end
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int lat, bw, br, bd, bdn, ba;
      logic e2;
      repeat (3) @(negedge clk);
      chk("rst_status", {busy, done, error}, 3'b000);
      chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
      chk("prot_strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
      @(posedge clk) #2 rst = 0;
      // 1: zero-wait slave
      bw = wr_n; br = rd_n; bd = drop_n; bdn = done_n;
      run(0, 0, lat, e2);
      chk("t1_latency", lat, 26);
      chk("t1_error", error, 0);
      chk("t1_busy_at_done", busy, 0);
      @(negedge clk);
      chk("t1_done_width", done, 0);
      chk("t1_busy_after", busy, 0);
      chk("t1_wr_count", wr_n - bw, 4);
      chk("t1_rd_count", rd_n - br, 4);
      chk("t1_done_count", done_n - bdn, 1);
      chk("t1_drops", drop_n - bd, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_waddr%0d", i), wr_a_log[bw + i], 32'(4 * i));
         chk($sformatf("t1_wdata%0d", i), wr_d_log[bw + i], 32'(i + 1));
         chk($sformatf("t1_raddr%0d", i), rd_a_log[br + i], 32'(4 * i));
      end
      // 2: skewed readies, wready ahead of awready on the first word
      bw = wr_n; bd = drop_n;
      for (int i = 0; i < 4; i++) begin
         cfg_aw_dly[bw + i] = int'($urandom_range(0, 5));
         cfg_w_dly[bw + i] = int'($urandom_range(0, 5));
      end
      cfg_aw_dly[bw] = 4; cfg_w_dly[bw] = 0;
      cfg_aw_dly[bw + 1] = 0; cfg_w_dly[bw + 1] = 3;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      run(0, 0, lat, e2);
      chk("t2_done", lat != 0, 1);
      chk("t2_error", error, 0);
      chk("t2_drops", drop_n - bd, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_wdata%0d", i), wr_d_log[bw + i], 32'(i + 1));
         chk($sformatf("t2_mem%0d", i), mem[i], 32'(i + 1));
      end
      // 3: corrupted read of word 2, then a clean rerun
      bad_r_word = 2; br = rd_n;
      run(0, 0, lat, e2);
      chk("t3_done", lat != 0, 1);
      chk("t3_error", error, 1);
      chk("t3_rd_count", rd_n - br, 4);
      bad_r_word = -1;
      run(0, 0, lat, e2);
      chk("t3_err_cleared", e2, 0);
      chk("t3_err_end", error, 0);
      // 4: SLVERR on word 1
      bad_b_word = 1; bw = wr_n; br = rd_n;
      run(0, 0, lat, e2);
      chk("t4_error", error, 1);
      chk("t4_wr_count", wr_n - bw, 4);
      chk("t4_rd_count", rd_n - br, 4);
      bad_b_word = -1;
      // 5: arready never comes
      ar_never = 1; ba = arv_n; br = rd_n;
      run(0, 0, lat, e2);
      chk("t5_latency", lat, 31);
      chk("t5_arvalid_cycles", arv_n - ba, 16);
      chk("t5_error", error, 1);
      chk("t5_arvalid_at_done", arvalid, 0);
      chk("t5_rd_count", rd_n - br, 0);
      ar_never = 0;
      // 6: reset in WR_ADDR, held init level, pulse while busy
      cfg_aw_dly[wr_n] = 10; cfg_w_dly[wr_n] = 10;
      @(negedge clk) init_txn = 1;
      @(negedge clk) init_txn = 0;
      for (int k = 0; k < 10 && !awvalid; k++) @(negedge clk);
      chk("t6_awvalid_seen", awvalid, 1);
      #2 rst = 1;
      #1;
      chk("t6_valids_async", {awvalid, wvalid}, 2'b00);
      chk("t6_busy_async", busy, 0);
      @(posedge clk) #2 rst = 0;
      cfg_aw_dly[wr_n] = 0; cfg_w_dly[wr_n] = 0;
      repeat (5) @(negedge clk);
      chk("t6_no_resume", {busy, awvalid, wvalid}, 3'b000);
      bdn = done_n;
      run(1, 0, lat, e2);
      repeat (40) @(negedge clk);
      chk("t6_held_done_count", done_n - bdn, 1);
      chk("t6_held_busy", busy, 0);
      init_txn = 0;
      @(negedge clk);
      bdn = done_n;
      run(0, 5, lat, e2);
      repeat (40) @(negedge clk);
      chk("t6_pulse_done_count", done_n - bdn, 1);
      chk("t6_pulse_error", error, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
